// File: rtl/hazard_forward_ctrl_pkg.sv
// hazard_forward_ctrl_pkg: shared encodings for the pipeline hazard and forwarding controller.
package hazard_forward_ctrl_pkg;
   localparam int REG_AW = 5;
   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b01;
   localparam logic [1:0] FWD_MEMWB   = 2'b10;
   localparam logic [1:0] PC_SEQ      = 2'b00;
   localparam logic [1:0] PC_BRANCH   = 2'b10;
   typedef enum logic [1:0] {RUN, STALL, REDIRECT} state_t;
endpackage

// File: rtl/hazard_shadow_pipe.sv
// hazard_shadow_pipe: EX/MEM/WB shadow of rd/regw/memr, advancing every cycle with bubble insert.
module hazard_shadow_pipe #(
   parameter int REG_AW = hazard_forward_ctrl_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bubble,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regw,
   input  logic              id_memr,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_regw,
   output logic              ex_memr,
   output logic [REG_AW-1:0] mem_rd,
   output logic              mem_regw,
   output logic              mem_memr,
   output logic [REG_AW-1:0] wb_rd,
   output logic              wb_regw,
   output logic              wb_memr
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         {ex_rd, ex_regw, ex_memr}    <= '0;
         {mem_rd, mem_regw, mem_memr} <= '0;
         {wb_rd, wb_regw, wb_memr}    <= '0;
      end else begin
         {wb_rd, wb_regw, wb_memr}    <= {mem_rd, mem_regw, mem_memr};
         {mem_rd, mem_regw, mem_memr} <= {ex_rd, ex_regw, ex_memr};
         {ex_rd, ex_regw, ex_memr}    <= bubble ? '0 : {id_rd, id_regw, id_memr};
      end
endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX operand forwarding selects, load-use stalls and redirect flushes
// for the IF/ID/EX/MEM/WB pipeline.
module hazard_forward_ctrl #(
   parameter int REG_AW            = hazard_forward_ctrl_pkg::REG_AW,
   parameter int LOAD_STALL_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regw,
   input  logic              id_memr,
   input  logic [1:0]        ex_pc_src,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall_busy
);
   import hazard_forward_ctrl_pkg::*;
   state_t state, state_nxt;
   logic [1:0] cnt, cnt_nxt, fwd_a_nxt, fwd_b_nxt;
   logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
   logic ex_regw, ex_memr, mem_regw, mem_memr, wb_regw, wb_memr;
   logic redirect, load_use, unused_wb;

   function automatic logic hit(input logic use_rs, input logic [REG_AW-1:0] rs,
                                input logic regw, input logic [REG_AW-1:0] rd);
      return use_rs && regw && rd != '0 && rd == rs;
   endfunction

   hazard_shadow_pipe #(.REG_AW(REG_AW)) u_shadow (
      .clk(clk), .rst(rst), .bubble(idex_flush),
      .id_rd(id_rd), .id_regw(id_regw), .id_memr(id_memr),
      .ex_rd(ex_rd), .ex_regw(ex_regw), .ex_memr(ex_memr),
      .mem_rd(mem_rd), .mem_regw(mem_regw), .mem_memr(mem_memr),
      .wb_rd(wb_rd), .wb_regw(wb_regw), .wb_memr(wb_memr)
   );

   // The WB entry is kept for observability only; forwarding never sources from it.
   assign unused_wb = ^{wb_rd, wb_regw, wb_memr};

   always_comb begin
      redirect   = rst && ex_pc_src != PC_SEQ;
      load_use   = ex_memr && (hit(id_use_rs1, id_rs1, ex_regw, ex_rd) || hit(id_use_rs2, id_rs2, ex_regw, ex_rd));
      fwd_a_nxt  = hit(id_use_rs1, id_rs1, ex_regw, ex_rd)   ? FWD_EXMEM :
                   hit(id_use_rs1, id_rs1, mem_regw, mem_rd) ? FWD_MEMWB : FWD_REGFILE;
      fwd_b_nxt  = hit(id_use_rs2, id_rs2, ex_regw, ex_rd)   ? FWD_EXMEM :
                   hit(id_use_rs2, id_rs2, mem_regw, mem_rd) ? FWD_MEMWB : FWD_REGFILE;
      state_nxt  = RUN;
      cnt_nxt    = '0;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      // REDIRECT ignores a second redirect while the first bubble drains
      if (state != REDIRECT && redirect) begin
         state_nxt  = REDIRECT;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if ((state == RUN && load_use) || (state == STALL && cnt != '0)) begin
         state_nxt  = STALL;
         cnt_nxt    = state == RUN ? 2'(LOAD_STALL_CYCLES - 1) : cnt - 2'd1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= RUN;
         cnt   <= '0;
         fwd_a <= FWD_REGFILE;
         fwd_b <= FWD_REGFILE;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         fwd_a <= idex_flush ? FWD_REGFILE : fwd_a_nxt;
         fwd_b <= idex_flush ? FWD_REGFILE : fwd_b_nxt;
      end

   assign stall_busy = state != RUN;
endmodule
